mtsp_unpack_pixel: RTL and testbench

- Multi-channel, pipelined successor to the single-element DWORD-to-byte unpacker.
- Accepts CH signed fixed-point channel values per beat, then applies a run-time fractional shift, optional rounding and unsigned or signed saturation.
- Packs the CH saturated results into one output word, with per-channel saturation flags.
- Sits between the MTSP ALU writeback and the pixel/texture store path. Uses a valid/ready handshake on both sides and keeps a saturation-event counter for debug.

---
 rtl/mtsp_unpack_pixel.sv | 183 ++++++++++++++++++
 tb/tb_mtsp_unpack_pixel.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_unpack_pixel.sv
// mtsp_unpack_pixel: multi-channel fixed-point to packed-pixel converter.
// Each beat carries CH signed channels. Stage 1 applies an optional half-up
// rounding offset and an arithmetic right shift. Stage 2 clamps each channel
// to an unsigned or signed OUT_W-bit range, packs the channels and flags any
// channel that was clamped. Both stages use valid/ready with full throughput.
module mtsp_unpack_pixel #(
    parameter int CH    = 4,
    parameter int IN_W  = 24,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [CH*IN_W-1:0]    IN_DATA,
    input  logic [4:0]            IN_FRAC,
    input  logic                  IN_ROUND,
    input  logic                  IN_SIGNED,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [CH*OUT_W-1:0]   OUT_DATA,
    output logic [CH-1:0]         OUT_SAT,
    output logic [CNT_W-1:0]      SAT_CNT,
    input  logic                  CNT_CLR
);

    // Largest meaningful shift; anything above it behaves like it.
    localparam logic [4:0]       FMAX    = 5'(IN_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Sign-extend to IN_W+1 bits, optionally add 2^(F-1), then shift right
    // arithmetically. The extra bit absorbs the rounding carry, so the
    // positive extreme cannot wrap negative.
    function automatic logic signed [IN_W:0] shift_round(
        input logic signed [IN_W-1:0] x,
        input logic [4:0]             frac,
        input logic                   rnd
    );
        logic signed [IN_W:0] v;
        logic signed [IN_W:0] one;
        logic [4:0]           f;
        f   = (frac > FMAX) ? FMAX : frac;
        v   = {x[IN_W-1], x};
        one = '0;
        one[0] = 1'b1;
        if (rnd && (f != 5'd0)) begin
            v = v + (one <<< (f - 5'd1));
        end
        return v >>> f;
    endfunction

    // Clamp one channel; returns {clamped_flag, OUT_W-bit result}.
    // Range tests look at the bits above the output field instead of
    // comparing against wide constants.
    function automatic logic [OUT_W:0] sat_chan(
        input logic signed [IN_W:0] r,
        input logic                 sgn
    );
        logic [IN_W-OUT_W+1:0] hi;
        hi = r[IN_W:OUT_W-1];
        if (!sgn) begin
            if (r[IN_W]) begin
                return {1'b1, {OUT_W{1'b0}}};
            end else if (|r[IN_W-1:OUT_W]) begin
                return {1'b1, {OUT_W{1'b1}}};
            end else begin
                return {1'b0, r[OUT_W-1:0]};
            end
        end else begin
            if ((&hi) || !(|hi)) begin
                return {1'b0, r[OUT_W-1:0]};
            end else if (r[IN_W]) begin
                return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    endfunction

    logic                 vld_p1_q;
    logic                 sgn_p1_q;
    logic signed [IN_W:0] r_p1_q [CH];
    logic signed [IN_W:0] r_p1_d [CH];

    logic                 vld_p2_q;
    logic [CH*OUT_W-1:0]  data_p2_q;
    logic [CH*OUT_W-1:0]  data_p2_d;
    logic [CH-1:0]        sat_p2_q;
    logic [CH-1:0]        sat_p2_d;

    logic [CNT_W-1:0]     sat_cnt_q;
    logic [CNT_W-1:0]     sat_cnt_d;

    logic                 s2_load;
    logic                 s1_load;
    logic                 out_acc;

    // Handshake: a stage loads when its holding register is empty or drains.
    always_comb begin
        s2_load = !vld_p2_q || OUT_READY;
        s1_load = !vld_p1_q || s2_load;
        out_acc = vld_p2_q && OUT_READY;
    end

    assign IN_READY  = s1_load;
    assign OUT_VALID = vld_p2_q;
    assign OUT_DATA  = data_p2_q;
    assign OUT_SAT   = sat_p2_q;
    assign SAT_CNT   = sat_cnt_q;

    // ---- stage 0 -> 1: round and shift every input channel
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            r_p1_d[i] = shift_round(IN_DATA[i*IN_W +: IN_W], IN_FRAC, IN_ROUND);
        end
    end

    // Stage 1 valid; a held beat is discarded by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1_q <= 1'b0;
        end else if (s1_load) begin
            vld_p1_q <= IN_VALID;
        end
    end

    // Stage 1 payload, captured together with the sign mode of the beat.
    always_ff @(posedge CLK) begin
        if (s1_load && IN_VALID) begin
            r_p1_q   <= r_p1_d;
            sgn_p1_q <= IN_SIGNED;
        end
    end

    // ---- stage 1 -> 2: clamp, pack and flag every channel
    always_comb begin
        logic [OUT_W:0] s;
        s         = '0;
        data_p2_d = '0;
        sat_p2_d  = '0;
        for (int i = 0; i < CH; i++) begin
            s = sat_chan(r_p1_q[i], sgn_p1_q);
            data_p2_d[i*OUT_W +: OUT_W] = s[OUT_W-1:0];
            sat_p2_d[i]                 = s[OUT_W];
        end
    end

    // Output register; held unchanged while the consumer stalls it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            sat_p2_q  <= '0;
        end else if (s2_load) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= data_p2_d;
                sat_p2_q  <= sat_p2_d;
            end
        end
    end

    // Saturation event counter: clear wins, otherwise count and stick at max.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (CNT_CLR) begin
            sat_cnt_d = '0;
        end else if (out_acc && (|sat_p2_q) && (sat_cnt_q != CNT_MAX)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mtsp_unpack_pixel.sv
// Testbench for mtsp_unpack_pixel: directed cases plus a randomized stream
// checked against an integer-arithmetic reference model.
module tb_mtsp_unpack_pixel;

    localparam int CH    = 4;
    localparam int IN_W  = 24;
    localparam int OUT_W = 8;
    localparam int CNT_W = 2;

    logic                 CLK;
    logic                 RST;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [CH*IN_W-1:0]   IN_DATA;
    logic [4:0]           IN_FRAC;
    logic                 IN_ROUND;
    logic                 IN_SIGNED;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [CH*OUT_W-1:0]  OUT_DATA;
    logic [CH-1:0]        OUT_SAT;
    logic [CNT_W-1:0]     SAT_CNT;
    logic                 CNT_CLR;

    int checks = 0;
    int errors = 0;

    mtsp_unpack_pixel #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .IN_FRAC(IN_FRAC), .IN_ROUND(IN_ROUND), .IN_SIGNED(IN_SIGNED),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_SAT(OUT_SAT), .SAT_CNT(SAT_CNT), .CNT_CLR(CNT_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: value / 2^F with optional +2^(F-1), then clamp to the range.
    function automatic void model_beat(
        input  logic [CH*IN_W-1:0]  d,
        input  logic [4:0]          f,
        input  logic                rnd,
        input  logic                sgn,
        output logic [CH*OUT_W-1:0] od,
        output logic [CH-1:0]       os
    );
        od = '0;
        os = '0;
        for (int i = 0; i < CH; i++) begin
            logic signed [IN_W-1:0] x;
            longint v, lo, hi;
            int fe;
            x  = d[i*IN_W +: IN_W];
            v  = x;
            fe = (int'(f) > IN_W - 1) ? IN_W - 1 : int'(f);
            if (rnd && fe > 0) v = v + (longint'(1) << (fe - 1));
            v  = v >>> fe;
            lo = sgn ? -(longint'(1) << (OUT_W - 1)) : 0;
            hi = sgn ? (longint'(1) << (OUT_W - 1)) - 1 : (longint'(1) << OUT_W) - 1;
            if (v < lo) begin v = lo; os[i] = 1'b1; end
            else if (v > hi) begin v = hi; os[i] = 1'b1; end
            od[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
    endfunction

    function automatic logic [CH*IN_W-1:0] rand_data();
        logic [CH*IN_W-1:0] d;
        logic signed [31:0] t;
        d = '0;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 3))
                0: t = $signed($urandom);
                1: t = $signed($urandom_range(0, 700)) - 350;
                2: t = 32'sh007F_FFFF;
                default: t = -32'sh0080_0000;
            endcase
            d[i*IN_W +: IN_W] = t[IN_W-1:0];
        end
        return d;
    endfunction

    // Send one beat into an idle pipe with OUT_READY high and collect it.
    task automatic send_and_get(
        input  logic [CH*IN_W-1:0]  d,
        input  logic [4:0]          f,
        input  logic                rnd,
        input  logic                sgn,
        output logic [CH*OUT_W-1:0] od,
        output logic [CH-1:0]       os,
        output int                  lat
    );
        od = '0; os = '0; lat = -1;
        OUT_READY = 1'b1;
        IN_DATA = d; IN_FRAC = f; IN_ROUND = rnd; IN_SIGNED = sgn;
        IN_VALID = 1'b1;
        for (int w = 0; w < 10; w++) begin
            @(negedge CLK);
            if (IN_READY) break;
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                od = OUT_DATA; os = OUT_SAT; lat = k;
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; CNT_CLR = 1'b0;
        IN_DATA = '0; IN_FRAC = '0; IN_ROUND = 1'b0; IN_SIGNED = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== '0 || OUT_SAT !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b data=%h sat=%b want 0/0/0", OUT_VALID, OUT_DATA, OUT_SAT);
        end
        checks++;
        if (SAT_CNT !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", SAT_CNT);
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", IN_READY);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_legacy();
        logic [CH*OUT_W-1:0] od; logic [CH-1:0] os; int lat;
        send_and_get({24'h000100, 24'h00007F, 24'h800000, 24'h000123}, 5'd0, 1'b0, 1'b0, od, os, lat);
        checks++;
        if (od !== 32'hFF7F00FF || os !== 4'b1011) begin
            errors++;
            $display("FAIL legacy: got data=%h sat=%b want FF7F00FF/1011", od, os);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL legacy_latency: got %0d want 2", lat);
        end
    endtask

    task automatic test_rounding();
        logic [CH*OUT_W-1:0] od; logic [CH-1:0] os; int lat;
        send_and_get({72'h0, 24'h000018}, 5'd4, 1'b1, 1'b0, od, os, lat);
        checks++;
        if (od !== 32'h00000002 || os !== 4'b0000) begin
            errors++;
            $display("FAIL round_on: got data=%h sat=%b want 00000002/0000", od, os);
        end
        send_and_get({72'h0, 24'h000018}, 5'd4, 1'b0, 1'b0, od, os, lat);
        checks++;
        if (od !== 32'h00000001 || os !== 4'b0000) begin
            errors++;
            $display("FAIL round_off: got data=%h sat=%b want 00000001/0000", od, os);
        end
        send_and_get({72'h0, 24'h7FFFFF}, 5'd1, 1'b1, 1'b0, od, os, lat);
        checks++;
        if (od !== 32'h000000FF || os !== 4'b0001) begin
            errors++;
            $display("FAIL round_max: got data=%h sat=%b want 000000FF/0001", od, os);
        end
        // Shift larger than IN_W-1 behaves as IN_W-1: -2^23 >> 23 = -1.
        send_and_get({72'h0, 24'h800000}, 5'd31, 1'b0, 1'b1, od, os, lat);
        checks++;
        if (od !== 32'h000000FF || os !== 4'b0000) begin
            errors++;
            $display("FAIL frac_limit: got data=%h sat=%b want 000000FF/0000", od, os);
        end
    endtask

    task automatic test_signed_clamp();
        logic [CH*OUT_W-1:0] od; logic [CH-1:0] os; int lat;
        send_and_get({24'h00007F, 24'hFFFFF0, 24'hFFFF70, 24'h000090}, 5'd0, 1'b0, 1'b1, od, os, lat);
        checks++;
        if (od !== 32'h7FF0807F || os !== 4'b0011) begin
            errors++;
            $display("FAIL signed_clamp: got data=%h sat=%b want 7FF0807F/0011", od, os);
        end
    endtask

    task automatic test_backpressure();
        logic [CH*IN_W-1:0]  bd [3];
        logic [CH*OUT_W-1:0] ed [3];
        logic [CH-1:0]       es [3];
        logic [CH*OUT_W-1:0] gd [3];
        logic [CH-1:0]       gs [3];
        int gc [3];
        int n;
        for (int i = 0; i < 3; i++) begin
            bd[i] = rand_data();
            model_beat(bd[i], 5'd2, 1'b1, 1'b1, ed[i], es[i]);
        end
        OUT_READY = 1'b0; IN_FRAC = 5'd2; IN_ROUND = 1'b1; IN_SIGNED = 1'b1;
        for (int i = 0; i < 2; i++) begin
            IN_DATA = bd[i]; IN_VALID = 1'b1;
            @(negedge CLK);
            checks++;
            if (IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept_%0d: in_ready got %b want 1", i, IN_READY);
            end
            @(posedge CLK); #1;
        end
        IN_DATA = bd[2];
        // Change sampled config; beats in flight must keep their own.
        IN_FRAC = 5'd0; IN_ROUND = 1'b0; IN_SIGNED = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT_DATA !== ed[0]) begin
                errors++;
                $display("FAIL bp_hold_%0d: rdy=%b vld=%b data=%h want 0/1/%h", k, IN_READY, OUT_VALID, OUT_DATA, ed[0]);
            end
            @(posedge CLK); #1;
        end
        IN_FRAC = 5'd2; IN_ROUND = 1'b1; IN_SIGNED = 1'b1;
        OUT_READY = 1'b1;
        n = 0;
        for (int c = 0; c < 12 && n < 3; c++) begin
            logic acc;
            @(negedge CLK);
            acc = IN_VALID && IN_READY;
            if (OUT_VALID) begin
                gd[n] = OUT_DATA; gs[n] = OUT_SAT; gc[n] = c; n++;
            end
            @(posedge CLK); #1;
            if (acc) IN_VALID = 1'b0;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gd[i] !== ed[i] || gs[i] !== es[i]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: got %h/%b want %h/%b", i, gd[i], gs[i], ed[i], es[i]);
                end
            end
            checks++;
            if (gc[1] !== gc[0] + 1 || gc[2] !== gc[1] + 1) begin
                errors++;
                $display("FAIL bp_consecutive: got cycles %0d,%0d,%0d want consecutive", gc[0], gc[1], gc[2]);
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic test_counter();
        int exp_cnt, sent;
        CNT_CLR = 1'b1;
        @(posedge CLK); #1;
        CNT_CLR = 1'b0;
        @(negedge CLK);
        checks++;
        if (SAT_CNT !== '0) begin
            errors++;
            $display("FAIL cnt_clear: got %0d want 0", SAT_CNT);
        end
        // Five back-to-back beats that each saturate channel 0.
        OUT_READY = 1'b1; IN_FRAC = 5'd0; IN_ROUND = 1'b0; IN_SIGNED = 1'b0;
        IN_DATA = {72'h0, 24'h000400};
        exp_cnt = 0; sent = 0;
        @(posedge CLK); #1;
        IN_VALID = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic acc_in, acc_out;
            @(negedge CLK);
            checks++;
            if (SAT_CNT !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL cnt_track_%0d: got %0d want %0d", c, SAT_CNT, exp_cnt);
            end
            acc_in  = IN_VALID && IN_READY;
            acc_out = OUT_VALID && OUT_READY && (|OUT_SAT);
            @(posedge CLK); #1;
            if (acc_out && exp_cnt < 3) exp_cnt++;
            if (acc_in) begin
                sent++;
                if (sent == 5) IN_VALID = 1'b0;
            end
        end
        checks++;
        if (SAT_CNT !== 2'd3) begin
            errors++;
            $display("FAIL cnt_stick: got %0d want 3", SAT_CNT);
        end
        // Clear coinciding with a saturating accept.
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (OUT_VALID) break;
        end
        CNT_CLR = 1'b1;
        @(posedge CLK); #1;
        CNT_CLR = 1'b0;
        checks++;
        if (SAT_CNT !== '0) begin
            errors++;
            $display("FAIL cnt_clr_priority: got %0d want 0", SAT_CNT);
        end
    endtask

    task automatic test_reset_midstream();
        logic [CH*OUT_W-1:0] od; logic [CH-1:0] os; int lat;
        int seen;
        send_and_get({72'h0, 24'hFFFFFF}, 5'd0, 1'b0, 1'b0, od, os, lat);
        @(negedge CLK);
        checks++;
        if (SAT_CNT !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre_cnt: got %0d want 1", SAT_CNT);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        IN_DATA = {72'h0, 24'h000055}; IN_SIGNED = 1'b0; IN_FRAC = 5'd0; IN_ROUND = 1'b0;
        IN_VALID = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        IN_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL rst_prestall: vld=%b rdy=%b want 1/0", OUT_VALID, IN_READY);
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b0 || SAT_CNT !== '0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: vld=%b cnt=%0d rdy=%b want 0/0/1", OUT_VALID, SAT_CNT, IN_READY);
        end
        checks++;
        if (OUT_DATA !== '0 || OUT_SAT !== '0) begin
            errors++;
            $display("FAIL rst_mid_data: data=%h sat=%b want 0/0", OUT_DATA, OUT_SAT);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge CLK);
            if (OUT_VALID) seen++;
            @(posedge CLK); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_stale: got %0d stale beats want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [CH*OUT_W-1:0] qd [$];
        logic [CH-1:0]       qs [$];
        int exp_cnt;
        CNT_CLR = 1'b1;
        @(posedge CLK); #1;
        CNT_CLR = 1'b0;
        exp_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic in_acc, out_acc;
            if (cyc < 560) begin
                IN_VALID  = ($urandom_range(0, 9) < 7);
                OUT_READY = ($urandom_range(0, 9) < 6);
                IN_DATA   = rand_data();
                IN_FRAC   = 5'($urandom_range(0, 31));
                IN_ROUND  = 1'($urandom_range(0, 1));
                IN_SIGNED = 1'($urandom_range(0, 1));
            end else begin
                IN_VALID  = 1'b0;
                OUT_READY = 1'b1;
            end
            @(negedge CLK);
            in_acc  = IN_VALID && IN_READY;
            out_acc = OUT_VALID && OUT_READY;
            checks++;
            if (SAT_CNT !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL rand_cnt_%0d: got %0d want %0d", cyc, SAT_CNT, exp_cnt);
            end
            if (out_acc) begin
                checks++;
                if (qd.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_%0d: got beat %h want none", cyc, OUT_DATA);
                end else begin
                    logic [CH*OUT_W-1:0] ed; logic [CH-1:0] es;
                    ed = qd.pop_front(); es = qs.pop_front();
                    if (OUT_DATA !== ed || OUT_SAT !== es) begin
                        errors++;
                        $display("FAIL rand_beat_%0d: got %h/%b want %h/%b", cyc, OUT_DATA, OUT_SAT, ed, es);
                    end
                    if (|es && exp_cnt < 3) exp_cnt++;
                end
            end
            if (in_acc) begin
                logic [CH*OUT_W-1:0] md; logic [CH-1:0] ms;
                model_beat(IN_DATA, IN_FRAC, IN_ROUND, IN_SIGNED, md, ms);
                qd.push_back(md); qs.push_back(ms);
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (qd.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got %0d beats left want 0", qd.size());
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_rounding();
        test_signed_clamp();
        test_backpressure();
        test_counter();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
